// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the store path of the RISC-V core:
//   STORE_SB / STORE_SH / STORE_SW : store-width funct3 encodings
//   store_state_t                  : store unit FSM states (IDLE / REQ / RESP)
//   STORE_CNT_W                    : width of the response timeout counter
// ----------------------------------------------------------------------------
package rv_pkg;

  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;

  localparam int unsigned STORE_CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } store_state_t;

endpackage

// File: rtl/rv_store_unit_if.sv
// ----------------------------------------------------------------------------
// rv_store_unit_if
// Data-memory write bus between the store unit (master) and memory (slave).
//   o_bus_valid  : write request from the store unit
//   i_bus_ready  : memory accepts the request
//   o_bus_addr   : word address [31:2]
//   o_bus_wdata  : lane-steered write data
//   o_bus_wstrb  : byte strobes
//   i_bus_ack    : write completed
// Signal names keep the store unit's point of view (o_ = driven by it).
// ----------------------------------------------------------------------------
interface rv_store_unit_if;

  logic        o_bus_valid;
  logic        i_bus_ready;
  logic [29:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_wstrb;
  logic        i_bus_ack;

  modport master (
    output o_bus_valid,
    output o_bus_addr,
    output o_bus_wdata,
    output o_bus_wstrb,
    input  i_bus_ready,
    input  i_bus_ack
  );

  modport slave (
    input  o_bus_valid,
    input  o_bus_addr,
    input  o_bus_wdata,
    input  o_bus_wstrb,
    output i_bus_ready,
    output i_bus_ack
  );

endinterface

// File: rtl/rv_store_align.sv
// ----------------------------------------------------------------------------
// rv_store_align
// Combinational byte-lane steering for stores.
//   i_addr_lo : addr[1:0] of the store
//   i_data    : store source register value
//   i_funct3  : store width (SB / SH / SW)
//   o_wdata   : data replicated onto every lane the width can occupy
//   o_wstrb   : byte strobes selecting the lanes actually written
//   o_illegal : request must not reach the bus
// Optional macro RV_STORE_MISALIGN_TRAP_EN: misaligned SH/SW become illegal;
// otherwise the ignored low address bits are simply dropped.
// ----------------------------------------------------------------------------
module rv_store_align
  import rv_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_illegal
);

  // Lane data, strobes and legality for the requested width.
  always_comb begin
    o_wdata   = 32'h0000_0000;
    o_wstrb   = 4'b0000;
    o_illegal = 1'b0;
    case (i_funct3)
      STORE_SB: begin
        o_wdata = {4{i_data[7:0]}};
        o_wstrb = 4'b0001 << i_addr_lo;
      end
      STORE_SH: begin
        // addr[0] never affects the lanes: a halfword sits in the low or high half.
        o_wdata = {2{i_data[15:0]}};
        o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
`ifdef RV_STORE_MISALIGN_TRAP_EN
        o_illegal = i_addr_lo[0];
`else
        o_illegal = 1'b0;
`endif
      end
      STORE_SW: begin
        o_wdata = i_data;
        o_wstrb = 4'b1111;
`ifdef RV_STORE_MISALIGN_TRAP_EN
        o_illegal = (i_addr_lo != 2'b00);
`else
        o_illegal = 1'b0;
`endif
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv_store_unit.sv
// ----------------------------------------------------------------------------
// rv_store_unit
// Store-side memory interface: accepts a store from the memory stage,
// registers the lane-steered data/strobes, runs the request/ack handshake on
// the data-memory bus and holds o_ready low until the store finishes.
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_valid / o_ready  : store request handshake (o_ready high only in IDLE)
//   i_addr, i_data     : byte address and source data
//   i_funct3           : store width
//   bus                : data-memory write bus (master side)
//   o_done / o_err     : one-cycle completion / error pulses
// Parameter TIMEOUT_CYCLES (1..1023): RESP cycles to wait for an ack.
// Optional macro RV_STORE_MISALIGN_TRAP_EN (see rv_store_align).
// ----------------------------------------------------------------------------
module rv_store_unit
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_data,
  input  logic [2:0]            i_funct3,
  rv_store_unit_if.master       bus,
  output logic                  o_done,
  output logic                  o_err
);

  // Last counter value that may still wait; the next RESP cycle without an
  // ack would be cycle number TIMEOUT_CYCLES + 1.
  localparam logic [STORE_CNT_W-1:0] TMO_LAST = STORE_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STORE_CNT_W-1:0] CNT_MAX  = {STORE_CNT_W{1'b1}};

  store_state_t            state_q, state_d;
  logic                    bus_valid_q, bus_valid_d;
  logic [29:0]             bus_addr_q, bus_addr_d;
  logic [31:0]             bus_wdata_q, bus_wdata_d;
  logic [3:0]              bus_wstrb_q, bus_wstrb_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [STORE_CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0]             lane_wdata;
  logic [3:0]              lane_wstrb;
  logic                    lane_illegal;

  rv_store_align u_align (
    .i_addr_lo (i_addr[1:0]),
    .i_data    (i_data),
    .i_funct3  (i_funct3),
    .o_wdata   (lane_wdata),
    .o_wstrb   (lane_wstrb),
    .o_illegal (lane_illegal)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (lane_illegal) begin
            err_d = 1'b1;
          end else begin
            state_d     = REQ;
            bus_valid_d = 1'b1;
            bus_addr_d  = i_addr[31:2];
            bus_wdata_d = lane_wdata;
            bus_wstrb_d = lane_wstrb;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.i_bus_ready) begin
          state_d     = RESP;
          bus_valid_d = 1'b0;
          cnt_d       = {STORE_CNT_W{1'b0}};
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (bus.i_bus_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q >= TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + {{(STORE_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  // State, bus output and pulse registers; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= 30'h0000_0000;
      bus_wdata_q <= 32'h0000_0000;
      bus_wstrb_q <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= {STORE_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_ready         = (state_q == IDLE);
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign bus.o_bus_valid = bus_valid_q;
  assign bus.o_bus_addr  = bus_addr_q;
  assign bus.o_bus_wdata = bus_wdata_q;
  assign bus.o_bus_wstrb = bus_wstrb_q;

endmodule

// File: doc/rv_store_unit.md
# rv_store_unit

Store-side memory interface of the RISC-V core pipeline. It accepts a store request from the memory stage, steers the store data onto the correct byte lanes of a 32-bit data bus, and generates byte strobes. It then runs the request/acknowledge handshake with the data memory and stalls the pipeline until the store completes. It is the write counterpart of the writeback load-extraction path: the load path pulls bytes and halfwords out of a word, and this block places them into one.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of cycles spent waiting for `i_bus_ack` before the store is abandoned. Range 1..1023.

Ports:
- `i_clk`, input, 1: core clock. All logic is on the rising edge.
- `i_reset`, input, 1: reset, **synchronous and active-high**.
- `i_valid`, input, 1: store request present.
- `o_ready`, output, 1: unit can accept a request (high only in IDLE).
- `i_addr`, input, 32: byte address of the store (ALU result).
- `i_data`, input, 32: store source register value.
- `i_funct3`, input, 3: store width. 000 = SB, 001 = SH, 010 = SW.
- `o_bus_valid`, output, 1: bus write request.
- `i_bus_ready`, input, 1: bus accepts the request.
- `o_bus_addr`, output, 30: word address [31:2].
- `o_bus_wdata`, output, 32: lane-steered write data.
- `o_bus_wstrb`, output, 4: byte strobes.
- `i_bus_ack`, input, 1: write completed.
- `o_done`, output, 1: one-cycle pulse when a store completes.
- `o_err`, output, 1: one-cycle pulse on an illegal funct3, a timeout, or (when configured) a misaligned store.

## Operation
- States are IDLE, REQ and RESP.
- **IDLE**
  - `o_ready` = 1.
  - When `i_valid` is high and the request is legal, register the address, lane data and strobes, then go to REQ.
  - When `i_valid` is high and the request is illegal, pulse `o_err` on the next cycle and stay in IDLE.
- **REQ**
  - `o_bus_valid` = 1. Address, data and strobes are held stable until `i_bus_ready`.
  - When `i_bus_ready` is high, go to RESP and clear the timeout counter.
- **RESP**
  - `i_bus_ack` returns to IDLE and pulses `o_done`.
  - If the counter reaches `TIMEOUT_CYCLES` without an ack, return to IDLE and pulse `o_err`.
  - Any `i_bus_ack` seen outside RESP is ignored.
- **Lane steering** (registered at accept):
  - SB: wdata = data[7:0] replicated ×4; wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = data[15:0] replicated ×2; wstrb = 4'b0011 << {addr[1], 1'b0}.
  - SW: wdata = data; wstrb = 4'b1111.
- **Illegal funct3:** 011 and 1xx. No bus activity occurs.
- **Timeout counter:** 10 bits, saturating. It counts only in RESP.
- **Reset:** synchronous, and has priority over every other input in any state.
  - State goes to IDLE.
  - `o_bus_valid`, `o_done` and `o_err` go to 0.
  - `o_bus_addr`, `o_bus_wdata` and `o_bus_wstrb` go to 0.
  - The counter goes to 0.
  - A store in progress when reset is asserted is abandoned with no `o_done`.

## Timing
- A request accepted at edge N gives `o_bus_valid` = 1 in cycle N+1, because all bus outputs are registered.
- Minimum store latency:
  - Accept at N; `i_bus_ready` in cycle N+1; ack in cycle N+2; `o_done` in cycle N+3.
  - `o_ready` returns high in cycle N+3.
- `o_ready` is a combinational decode of the state only. It never depends on `i_valid`.
- `o_done` and `o_err` are registered, last exactly one cycle, and are never high at the same time.
- Back-to-back stores are allowed: a new request may be accepted in the same cycle that `o_done` is high.

## Configuration
- Macro: `RV_STORE_MISALIGN_TRAP_EN`.
- **Defined:** the following are illegal and follow the IDLE illegal-request path (`o_err` pulse, no bus activity):
  - SH with addr[0] = 1.
  - SW with addr[1:0] ≠ 0.
- **Undefined:** the ignored low address bits are forced to zero and the store proceeds.
  - SH ignores addr[0].
  - SW ignores addr[1:0].

## Structure
- The shared package `rv_pkg` holds:
  - the store funct3 constants: `STORE_SB`, `STORE_SH`, `STORE_SW`;
  - the state enum: `store_state_t` (IDLE / REQ / RESP).
- Sub-module `rv_store_align` is purely combinational.
  - Inputs: addr[1:0], data, funct3.
  - Outputs: wdata, wstrb, illegal (the illegal flag includes the misalign check when the macro is set).
- The top level keeps only the FSM, the output registers and the counter.

## Test plan
- SB at addr 0x1003 with data 0xA5 → `o_bus_addr` = 0x400; wdata = 0xA5A5A5A5; wstrb = 4'b1000; `o_done` 3 cycles after accept when ready and ack are immediate.
- SH at 0x2002 with data 0x1234BEEF → wdata = 0xBEEFBEEF; wstrb = 4'b1100.
- SW at 0x10 with `i_bus_ready` held low for 5 cycles → bus outputs stay stable throughout; `o_ready` = 0 until `o_done`.
- SW at 0x11 → with the macro: `o_err` pulse, no `o_bus_valid`. Without the macro: wstrb = 4'b1111, `o_bus_addr` = 0x4.
- `TIMEOUT_CYCLES` = 4 with no ack → `o_err` pulse and return to IDLE after 4 cycles in RESP; funct3 = 3'b100 → `o_err`, no bus request.
- `i_reset` asserted while in RESP → on the next cycle all outputs are 0, `o_ready` = 1, and a late `i_bus_ack` produces no `o_done`.
